// File: rtl/intrapred_mb_scheduler_if.sv
// Handshake bundle between the intra-prediction MB scheduler and its host/pipeline.
interface intrapred_mb_scheduler_if #(
    parameter int MB_NUMBER_BITS = 12,
    parameter int PIPE_DEPTH     = 5
);
    logic                      start;
    logic                      abort;
    logic                      res_ready;
    logic [PIPE_DEPTH-1:0]     stage_en;
    logic [MB_NUMBER_BITS-1:0] mbnumber;
    logic                      res_valid;
    logic [MB_NUMBER_BITS-1:0] res_mbnumber;
    logic                      pipeline_full;
    logic                      busy;
    logic                      done;

    modport master (
        output start, abort, res_ready,
        input  stage_en, mbnumber, res_valid, res_mbnumber, pipeline_full, busy, done
    );

    modport slave (
        input  start, abort, res_ready,
        output stage_en, mbnumber, res_valid, res_mbnumber, pipeline_full, busy, done
    );
endinterface

// File: rtl/intrapred_mb_scheduler.sv
// Issues macroblock numbers into the intra-prediction pipeline, tags every stage,
// stalls the whole pipe on result back-pressure and drains at frame end.
module intrapred_mb_scheduler #(
    parameter int MB_NUMBER_BITS = 12,
    parameter int FRAME_MBS      = 99,
    parameter int PIPE_DEPTH     = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    intrapred_mb_scheduler_if.slave bus
);

    // state | meaning
    // IDLE  | no frame in flight; start issues MB 0
    // RUN   | one MB issued per advancing cycle
    // DRAIN | all MBs issued; bubbles shift in until the last result is accepted
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    // extra bit lets the count reach FRAME_MBS = 2^MB_NUMBER_BITS without wrapping
    localparam int CNT_BITS = MB_NUMBER_BITS + 1;
    localparam logic [CNT_BITS-1:0] FRAME_CNT = CNT_BITS'(FRAME_MBS);

    state_t                    state, state_nxt;
    logic [CNT_BITS-1:0]       issue_cnt;
    logic [PIPE_DEPTH-1:0]     valid_sr;
    logic [MB_NUMBER_BITS-1:0] tag [PIPE_DEPTH];
    logic [MB_NUMBER_BITS-1:0] mbnumber_q;

    logic busy, adv, accept, last_out;
    logic do_shift, do_issue, do_clear, done_evt;

    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign adv      = ~(valid_sr[PIPE_DEPTH-1] & ~bus.res_ready);
    assign accept   = valid_sr[PIPE_DEPTH-1] & bus.res_ready;
    assign last_out = accept && (valid_sr[PIPE_DEPTH-2:0] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_issue  = 1'b0;
        do_clear  = 1'b0;
        done_evt  = 1'b0;
        if (bus.abort) begin
            state_nxt = S_IDLE;
            do_clear  = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_nxt = S_RUN;
                        do_shift  = 1'b1;
                        do_issue  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (adv) begin
                        do_shift = 1'b1;
                        if (issue_cnt == FRAME_CNT) begin
                            state_nxt = S_DRAIN;
                        end else begin
                            do_issue = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (adv) begin
                        if (last_out) begin
                            state_nxt = S_IDLE;
                            do_clear  = 1'b1;
                            done_evt  = 1'b1;
                        end else begin
                            do_shift = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    do_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            valid_sr   <= '0;
            issue_cnt  <= '0;
            mbnumber_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                tag[k] <= '0;
            end
        end else if (do_shift) begin
            valid_sr <= {valid_sr[PIPE_DEPTH-2:0], do_issue};
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                tag[k] <= tag[k-1];
            end
            tag[0] <= do_issue ? issue_cnt[MB_NUMBER_BITS-1:0] : '0;
            if (do_issue) begin
                mbnumber_q <= issue_cnt[MB_NUMBER_BITS-1:0];
                issue_cnt  <= issue_cnt + CNT_BITS'(1);
            end
        end
    end

    assign bus.stage_en      = {PIPE_DEPTH{adv & busy}} & valid_sr;
    assign bus.mbnumber      = mbnumber_q;
    assign bus.res_valid     = valid_sr[PIPE_DEPTH-1];
    assign bus.res_mbnumber  = tag[PIPE_DEPTH-1];
    assign bus.pipeline_full = &valid_sr;
    assign bus.busy          = busy;
    // a reset landing on the final accept must not report a completed frame
    assign bus.done          = done_evt & ~reset;

endmodule

// File: tb/tb_intrapred_mb_scheduler.sv
// Bench: three scheduler instances (4, 8 and 1 MB frames) driven by shared stimulus,
// each compared every cycle against a slot-array reference and an in-order result counter.
module tb_intrapred_mb_scheduler;
    localparam int MB_BITS = 12;
    localparam int PD      = 5;
    localparam int N_INST  = 3;

    logic clk = 1'b0;
    logic reset, start, abort, res_ready;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [N_INST-1:0]  busy_v, rv_v, done_v, full_v;
    logic [MB_BITS-1:0] mbn_v [N_INST];
    logic [MB_BITS-1:0] rmb_v [N_INST];
    logic [PD-1:0]      en_v  [N_INST];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int FR = (gi == 0) ? 4 : ((gi == 1) ? 8 : 1);

        intrapred_mb_scheduler_if #(.MB_NUMBER_BITS(MB_BITS), .PIPE_DEPTH(PD)) bus ();

        assign bus.start     = start;
        assign bus.abort     = abort;
        assign bus.res_ready = res_ready;
        assign busy_v[gi]    = bus.busy;
        assign rv_v[gi]      = bus.res_valid;
        assign done_v[gi]    = bus.done;
        assign full_v[gi]    = bus.pipeline_full;
        assign mbn_v[gi]     = bus.mbnumber;
        assign rmb_v[gi]     = bus.res_mbnumber;
        assign en_v[gi]      = bus.stage_en;

        intrapred_mb_scheduler #(
            .MB_NUMBER_BITS(MB_BITS),
            .FRAME_MBS     (FR),
            .PIPE_DEPTH    (PD)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );

        // reference: MB number sitting in each stage, -1 for an empty slot
        int m_pipe [PD];
        int m_mode;   // 0 idle, 1 issuing, 2 draining
        int m_next, m_mbn, m_acc;
        bit u_rv, u_acc, u_last;
        bit e_rv, e_adv, e_busy, e_full, e_last, e_done;
        logic [PD-1:0] e_en;

        initial begin
            m_mode = 0; m_next = 0; m_mbn = 0; m_acc = 0;
            for (int k = 0; k < PD; k++) m_pipe[k] = -1;
        end

        always @(posedge clk) begin
            u_rv   = (m_pipe[PD-1] >= 0);
            u_acc  = u_rv && res_ready;
            u_last = u_acc;
            for (int k = 0; k < PD-1; k++) if (m_pipe[k] >= 0) u_last = 0;
            if (reset || abort) begin
                m_mode = 0; m_next = 0; m_mbn = 0;
                for (int k = 0; k < PD; k++) m_pipe[k] = -1;
            end else if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1; m_pipe[0] = 0; m_mbn = 0; m_next = 1; m_acc = 0;
                end
            end else if (!u_rv || res_ready) begin
                if (u_acc) m_acc++;
                if (m_mode == 2 && u_last) begin
                    m_mode = 0; m_next = 0; m_mbn = 0;
                    for (int k = 0; k < PD; k++) m_pipe[k] = -1;
                end else begin
                    for (int k = PD-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
                    if (m_mode == 1 && m_next < FR) begin
                        m_pipe[0] = m_next; m_mbn = m_next; m_next++;
                    end else begin
                        m_pipe[0] = -1;
                        m_mode = 2;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                e_rv   = (m_pipe[PD-1] >= 0);
                e_adv  = !(e_rv && !res_ready);
                e_busy = (m_mode != 0);
                e_full = 1;
                e_last = e_rv;
                for (int k = 0; k < PD; k++) begin
                    e_en[k] = e_adv && e_busy && (m_pipe[k] >= 0);
                    if (m_pipe[k] < 0) e_full = 0;
                    if (k < PD-1 && m_pipe[k] >= 0) e_last = 0;
                end
                e_done = (m_mode == 2) && e_rv && res_ready && e_last && !abort && !reset;
                chk($sformatf("i%0d_busy", gi), 32'(bus.busy), 32'(e_busy));
                chk($sformatf("i%0d_res_valid", gi), 32'(bus.res_valid), 32'(e_rv));
                chk($sformatf("i%0d_full", gi), 32'(bus.pipeline_full), 32'(e_full));
                chk($sformatf("i%0d_stage_en", gi), 32'(bus.stage_en), 32'(e_en));
                chk($sformatf("i%0d_mbnumber", gi), 32'(bus.mbnumber), m_mbn);
                chk($sformatf("i%0d_done", gi), 32'(bus.done), 32'(e_done));
                if (e_rv) chk($sformatf("i%0d_res_mb", gi), 32'(bus.res_mbnumber), m_pipe[PD-1]);
                if (e_rv && res_ready && !abort && !reset)
                    chk($sformatf("i%0d_order", gi), 32'(bus.res_mbnumber), m_acc);
            end
        end
    end

    task automatic wait_idle();
        start = 0; abort = 0; reset = 0; res_ready = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (busy_v == '0) return;
        end
        chk("idle_timeout", 32'(busy_v), 0);
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; res_ready = 1;
        @(posedge clk); #1;
        chk_en = 1;
        start = 1; abort = 1;
        @(negedge clk);
        chk("rst_busy", 32'(busy_v), 0);
        chk("rst_res_valid", 32'(rv_v), 0);
        chk("rst_mbnumber", 32'(mbn_v[0]), 0);
        @(posedge clk); #1;
        reset = 0; start = 0; abort = 0;
        @(negedge clk);
        chk("rst_start_ignored", 32'(busy_v), 0);

        // basic frame, fill and single-MB frame; start at cycle 3 lands while busy
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 3);
            @(negedge clk);
            if (c >= 1 && c <= 4) chk("basic_mbnumber", 32'(mbn_v[0]), c - 1);
            if (c >= 5 && c <= 8) begin
                chk("basic_res_valid", 32'(rv_v[0]), 1);
                chk("basic_res_mb", 32'(rmb_v[0]), c - 5);
            end
            if (c == 7 || c == 8) chk("basic_done", 32'(done_v[0]), 32'(c == 8));
            if (c == 9) chk("basic_busy_fall", 32'(busy_v[0]), 0);
            if (c == 4 || c == 5) chk("fill_assert", 32'(full_v[1]), 32'(c == 5));
            if (c == 8 || c == 9) chk("fill_bubble", 32'(full_v[1]), 32'(c == 8));
            if (c == 5) begin
                chk("single_res_mb", 32'(rmb_v[2]), 0);
                chk("single_done", 32'(done_v[2]), 1);
            end
            if (c == 6) chk("single_busy_fall", 32'(busy_v[2]), 0);
        end
        wait_idle();

        // back-pressure for three cycles while MB 2 is at the output
        for (int c = 0; c <= 17; c++) begin
            @(posedge clk); #1;
            start     = (c == 0);
            res_ready = !(c >= 7 && c <= 9);
            @(negedge clk);
            if (c >= 7 && c <= 9) begin
                chk("bp_hold_mb", 32'(rmb_v[1]), 2);
                chk("bp_stage_en", 32'(en_v[1]), 0);
                chk("bp_hold_valid", 32'(rv_v[1]), 1);
            end
            if (c >= 7 && c <= 10) chk("bp_hold_issue", 32'(mbn_v[1]), 6);
            if (c == 10) chk("bp_resume_en", 32'(en_v[1]), (1 << PD) - 1);
            if (c == 14 || c == 15) chk("bp_done_delay", 32'(done_v[1]), 32'(c == 15));
        end
        wait_idle();

        // abort in the third RUN cycle, then start+abort together, then a clean restart
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 5) || (c == 6);
            abort = (c == 3) || (c == 5);
            @(negedge clk);
            if (c == 3) chk("ab_running", 32'(busy_v[0]), 1);
            if (c == 4) begin
                chk("ab_busy", 32'(busy_v), 0);
                chk("ab_res_valid", 32'(rv_v), 0);
                chk("ab_full", 32'(full_v), 0);
                chk("ab_done", 32'(done_v), 0);
                chk("ab_stage_en", 32'(en_v[1]), 0);
            end
            if (c == 6) chk("ab_start_and_abort", 32'(busy_v), 0);
            if (c == 7) begin
                chk("ab_restart_busy", 32'(busy_v[0]), 1);
                chk("ab_restart_mb", 32'(mbn_v[0]), 0);
            end
            if (c == 8) chk("ab_restart_mb1", 32'(mbn_v[0]), 1);
        end
        wait_idle();

        // reset mid-drain with start and abort also asserted
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 6);
            abort = (c == 6);
            reset = (c == 6);
            @(negedge clk);
            if (c == 6) chk("rs_in_drain", 32'(busy_v[0]), 1);
            if (c == 7) begin
                chk("rs_busy", 32'(busy_v), 0);
                chk("rs_res_valid", 32'(rv_v), 0);
                chk("rs_done", 32'(done_v), 0);
                chk("rs_full", 32'(full_v), 0);
                for (int i = 0; i < N_INST; i++) begin
                    chk("rs_mbnumber", 32'(mbn_v[i]), 0);
                    chk("rs_res_mb", 32'(rmb_v[i]), 0);
                    chk("rs_stage_en", 32'(en_v[i]), 0);
                end
            end
            if (c == 8) chk("rs_stay_idle", 32'(busy_v), 0);
        end
        wait_idle();

        // randomized traffic, checked by the per-instance references
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 499) == 0);
            abort     = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 15) == 0);
            res_ready = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 1) != 0);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
